// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_defs: shared definitions for the ALU operation sequencer.
//   - instruction field positions for the fixed 20-bit instruction word
//   - FSM state encoding
package alu_seq_defs;

   localparam int IW          = 20;
   localparam int OP_HI       = 19;
   localparam int OP_LO       = 17;
   localparam int USE_IMM_BIT = 16;
   localparam int WB_EN_BIT   = 15;
   localparam int RD_HI       = 14;
   localparam int RD_LO       = 13;
   localparam int RS_HI       = 12;
   localparam int RS_LO       = 11;
   localparam int RT_HI       = 10;
   localparam int RT_LO       = 9;
   localparam int RSVD_BIT    = 8;
   localparam int IMM_HI      = 7;
   localparam int IMM_LO      = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4 x 8-bit register file.
// Ports:
//   clk, reset            - clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata      - synchronous write port
//   raddr_a / rdata_a     - combinational operand read port A
//   raddr_b / rdata_b     - combinational operand read port B
//   dbg_sel / dbg_data    - combinational debug read port
module alu_regfile (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata,
   input  logic [1:0] raddr_a,
   input  logic [1:0] raddr_b,
   input  logic [1:0] dbg_sel,
   output logic [7:0] rdata_a,
   output logic [7:0] rdata_b,
   output logic [7:0] dbg_data
);

   logic [7:0] regs [4];

   // reset has priority, so a write pending on a reset edge is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a  = regs[raddr_a];
   assign rdata_b  = regs[raddr_b];
   assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives an external 8-bit ALU from a 4x8 register file.
// Accepts instruction words over valid/ready, registers ALU select/operands,
// writes the ALU result back and latches the ALU flags.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   instr, instr_valid, instr_ready  - instruction handshake
//   alu_s, alu_a, alu_b              - registered ALU select / operands
//   alu_f, alu_ovf, alu_take_branch  - ALU result and flags
//   done                             - one-cycle retire pulse
//   ovf_flag, branch_flag            - flags of the last retired instruction
//   dbg_sel, dbg_data                - combinational register debug read
//
// state | meaning
// IDLE  | ready for an instruction; operands captured on accept
// EXEC  | ALU inputs stable; result written back, flags latched at edge
// DONE  | retire pulse, not ready
module alu_op_sequencer
   import alu_seq_defs::*;
#(
   parameter int IW = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   output logic [2:0]    alu_s,
   output logic [7:0]    alu_a,
   output logic [7:0]    alu_b,
   input  logic [7:0]    alu_f,
   input  logic          alu_ovf,
   input  logic          alu_take_branch,
   output logic          done,
   output logic          ovf_flag,
   output logic          branch_flag,
   input  logic [1:0]    dbg_sel,
   output logic [7:0]    dbg_data
);

   state_t     state_q, state_d;
   logic       accept, exec;
   logic [1:0] rd_q;
   logic       wb_en_q;
   logic [7:0] rdata_a, rdata_b;

   logic [2:0] op;
   logic       use_imm, wb_en;
   logic [1:0] rd, rs, rt;
   logic [7:0] imm;
   logic       unused_rsvd;

   assign op          = instr[OP_HI:OP_LO];
   assign use_imm     = instr[USE_IMM_BIT];
   assign wb_en       = instr[WB_EN_BIT];
   assign rd          = instr[RD_HI:RD_LO];
   assign rs          = instr[RS_HI:RS_LO];
   assign rt          = instr[RT_HI:RT_LO];
   assign imm         = instr[IMM_HI:IMM_LO];
   assign unused_rsvd = instr[RSVD_BIT];

   alu_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (exec && wb_en_q),
      .waddr    (rd_q),
      .wdata    (alu_f),
      .raddr_a  (rs),
      .raddr_b  (rt),
      .dbg_sel  (dbg_sel),
      .rdata_a  (rdata_a),
      .rdata_b  (rdata_b),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // outputs are gated by reset so nothing is offered or retired while it is held
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;
      exec        = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = ~reset;
            if (instr_valid && !reset) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            exec    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = ~reset;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_s       <= 3'd0;
         alu_a       <= 8'd0;
         alu_b       <= 8'd0;
         rd_q        <= 2'd0;
         wb_en_q     <= 1'b0;
         ovf_flag    <= 1'b0;
         branch_flag <= 1'b0;
      end else begin
         if (accept) begin
            alu_s   <= op;
            alu_a   <= rdata_a;
            alu_b   <= use_imm ? imm : rdata_b;
            rd_q    <= rd;
            wb_en_q <= wb_en;
         end
         if (exec) begin
            ovf_flag    <= alu_ovf;
            branch_flag <= alu_take_branch;
         end
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencer sitting directly around the 8-bit ALU. It accepts encoded instruction words over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU select and operand inputs from registers, then captures the ALU result, overflow and branch outputs. The result is written back to the register file and the flags are latched. The ALU is instantiated beside this block at the top level; the sequencer replaces the VIO as the source of `s`/`a`/`b` and the consumer of `f`/`ovf`/`take_branch`.

## Interface
- `IW`, 20: instruction width; field map is fixed for this value.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in IW: instruction word.
  - [19:17] op (ALU select)
  - [16] use_imm
  - [15] wb_en
  - [14:13] rd
  - [12:11] rs
  - [10:9] rt
  - [8] reserved, ignored
  - [7:0] imm
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: block can accept an instruction.
- `alu_s` out 3: registered ALU select.
- `alu_a` out 8: registered first operand, R[rs].
- `alu_b` out 8: registered second operand, imm if use_imm else R[rt].
- `alu_f` in 8: ALU result.
- `alu_ovf` in 1: ALU overflow.
- `alu_take_branch` in 1: ALU branch condition.
- `done` out 1: one-cycle pulse when an instruction retires.
- `ovf_flag` out 1: latched `alu_ovf` of the last retired instruction.
- `branch_flag` out 1: latched `alu_take_branch` of the last retired instruction.
- `dbg_sel` in 2: register index for debug read.
- `dbg_data` out 8: combinational R[dbg_sel], for LEDs/VIO.

## Operation
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, load `alu_s`←op, `alu_a`←R[rs], `alu_b`←(use_imm ? imm : R[rt]).
  - Latch rd and wb_en; go to EXEC.
  - With no valid, stay in IDLE; all outputs hold.
- EXEC:
  - `instr_ready`=0; ALU inputs stable.
  - At the clock edge, if wb_en then R[rd]←`alu_f`.
  - `ovf_flag`←`alu_ovf` and `branch_flag`←`alu_take_branch` update unconditionally.
  - Go to DONE.
- DONE:
  - `done`=1 and `instr_ready`=0.
  - Go to IDLE.
- `alu_s`/`alu_a`/`alu_b` hold their last values after retirement until the next accept.
- The block does no arithmetic; all result and flag widths come from the ALU (8-bit result, 1-bit flags).
- rs, rt and rd may alias.
  - Operands are read at accept, write-back happens in EXEC, and there is never overlap, so no forwarding is needed.
- `instr_valid` asserted while not ready is ignored. The source must hold `instr` until it sees ready.
- The reserved bit and unused fields (rt when use_imm=1) have no effect.
- `dbg_data` reflects a write on the cycle after the write edge.

## Timing
- Reset values:
  - state=IDLE
  - R0..R3=0
  - `alu_s`/`alu_a`/`alu_b`=0
  - `ovf_flag`=`branch_flag`=0
  - `done`=0
  - `instr_ready`=0 while `reset` is high, 1 on the first cycle after it deasserts.
- Accept edge at the end of cycle N:
  - EXEC in N+1; ALU outputs are sampled at the end of N+1.
  - `done`=1 in N+2.
  - `instr_ready`=1 in N+3.
- Latency is 2 cycles accept-to-retire; throughput is 1 instruction per 3 cycles.
- `reset` in any state, including mid-EXEC, wins:
  - No write-back happens on that edge.
  - All state returns to reset values on the next cycle.
  - An in-flight instruction is dropped with no `done`.
- The ALU path `alu_a`/`alu_b`/`alu_s` → `alu_f` → R[rd] is a single-cycle combinational path through the ALU.

## Structure
- Shared package/header `alu_seq_defs`:
  - Instruction field position localparams (OP_HI/OP_LO, USE_IMM_BIT, WB_EN_BIT, RD/RS/RT positions, IMM_HI/IMM_LO).
  - State encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2).
- Sub-module `alu_regfile`:
  - 4×8 registers.
  - Two combinational read ports for operands, one combinational read port for debug.
  - One synchronous write port (we, waddr, wdata) with synchronous reset to zero.
- The FSM, operand registers and flag registers stay in `alu_op_sequencer`.
- The top level wires `alu_*` to the ALU and `dbg_data` to the LEDs.

## Test plan
- Reset and idle:
  - Assert reset 3 cycles, then release.
  - Required: all outputs 0 during reset, `instr_ready`=1 on the next cycle, `dbg_data`=0 for all 4 `dbg_sel`.
- Immediate load:
  - Stub ALU with f=b.
  - Send op=0, use_imm=1, wb_en=1, rd=2, imm=8'hA5.
  - Required: `alu_b`=A5 in N+1, `done` in N+2, R2=A5, `ready`=1 in N+3.
- Register operands and aliasing:
  - Preload R1=8'h0F (via imm), stub f=a+b.
  - Send rs=1, rt=1, rd=1.
  - Required: `alu_a`=`alu_b`=0F, R1=1E.
- Flags and no write-back:
  - Stub ovf=1, take_branch=1, f=8'hFF.
  - Send wb_en=0, rd=3.
  - Required: R3 unchanged, `ovf_flag`=1, `branch_flag`=1.
  - A following instruction with the stub returning 0 flags clears both flags.
- Handshake:
  - Hold `instr_valid`=1 continuously with changing `instr`.
  - Required: exactly one accept per 3 cycles, and words presented while `ready`=0 are never executed.
- Reset mid-EXEC:
  - Assert reset in N+1 of an instruction with rd=0, imm=8'h55.
  - Required: R0 stays 0, no `done` pulse, `ready`=1 on the cycle after reset deasserts.
